// File: rtl/vend_pkg.sv
// Shared definitions for the vending machine transaction sequencer.
//   state_t : controller states
//   Q_VAL   : credit value of a quarter, in quarters
//   D_VAL   : credit value of a dollar, in quarters
package vend_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    DISPENSE = 2'd1,
    CHANGE   = 2'd2,
    FAULT    = 2'd3
  } state_t;

  localparam int unsigned Q_VAL = 1;
  localparam int unsigned D_VAL = 4;

endpackage

// File: rtl/ack_watchdog.sv
// Handshake watchdog shared by the dispense and change handshakes.
// Ports:
//   clk, reset : clock, synchronous active-high reset
//   start      : the watched req is high for its first cycle
//   run        : a req is currently high
//   ack        : the matching ack is sampled high while its req is high
//   expired    : this is the TIMEOUT-th req-high cycle and no ack arrived
module ack_watchdog #(
  parameter int TIMEOUT = 255
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  input  logic run,
  input  logic ack,
  output logic expired
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  logic [CNT_W-1:0] cnt_p0;
  logic [CNT_W-1:0] cnt_eff;

  // The first req-high cycle counts as zero regardless of stale history.
  always_comb begin
    cnt_eff = start ? '0 : cnt_p0;
  end

  assign expired = run & ~ack & (cnt_eff == CNT_W'(TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_p0 <= '0;
    end else if (run) begin
      cnt_p0 <= cnt_eff + CNT_W'(1);
    end
  end

endmodule

// File: rtl/vend_controller.sv
// Vending machine transaction sequencer: coin credit, dispense handshake,
// change return one quarter at a time, watchdog fault lock.
// Ports:
//   clk, reset          : clock, synchronous active-high reset
//   quarter, dollar     : one-cycle coin pulses (+1 / +4 quarters)
//   vend_sel, cancel    : one-cycle product select / refund request
//   disp_ack, coin_ack  : actuator / hopper acknowledges
//   disp_req, coin_req  : level requests, held until ack
//   coin_reject         : one-cycle pulse, coins routed to reject chute
//   credit              : current credit in quarters
//   busy                : high in DISPENSE, CHANGE and FAULT
//   fault               : watchdog expired, sticky until reset
import vend_pkg::*;

module vend_controller #(
  parameter int PRICE_Q      = 4,
  parameter int MAX_CREDIT_Q = 15,
  parameter int CREDIT_W     = 4,
  parameter int TIMEOUT      = 255
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                quarter,
  input  logic                dollar,
  input  logic                vend_sel,
  input  logic                cancel,
  input  logic                disp_ack,
  input  logic                coin_ack,
  output logic                disp_req,
  output logic                coin_req,
  output logic                coin_reject,
  output logic [CREDIT_W-1:0] credit,
  output logic                busy,
  output logic                fault
);

  localparam int SUM_W = CREDIT_W + 1;

  state_t              state_p0;
  logic [CREDIT_W-1:0] credit_p0;
  logic                disp_req_p0;
  logic                coin_req_p0;
  logic                coin_reject_p0;
  logic                busy_p0;
  logic                fault_p0;
  logic                disp_req_p1;
  logic                coin_req_p1;

  logic                coin_in;
  logic                intake_ok;
  logic [SUM_W-1:0]    sum;
  logic [CREDIT_W-1:0] credit_post;
  logic                wd_start;
  logic                wd_run;
  logic                wd_ack;
  logic                expired;

  // One spare bit keeps credit + 5 exact for the limit comparison.
  function automatic logic [SUM_W-1:0] coin_sum(
    input logic [CREDIT_W-1:0] c,
    input logic                q,
    input logic                d
  );
    coin_sum = {1'b0, c}
             + SUM_W'(q ? Q_VAL : 0)
             + SUM_W'(d ? D_VAL : 0);
  endfunction

  always_comb begin
    coin_in     = quarter | dollar;
    sum         = coin_sum(credit_p0, quarter, dollar);
    intake_ok   = (sum <= SUM_W'(MAX_CREDIT_Q));
    credit_post = (coin_in && intake_ok) ? sum[CREDIT_W-1:0] : credit_p0;
  end

  // Req edges restart the watchdog; the low gap between change coins
  // guarantees each coin_req pulse gets its own full window.
  assign wd_start = (disp_req_p0 & ~disp_req_p1) | (coin_req_p0 & ~coin_req_p1);
  assign wd_run   = disp_req_p0 | coin_req_p0;
  assign wd_ack   = (disp_req_p0 & disp_ack) | (coin_req_p0 & coin_ack);

  ack_watchdog #(
    .TIMEOUT (TIMEOUT)
  ) u_watchdog (
    .clk     (clk),
    .reset   (reset),
    .start   (wd_start),
    .run     (wd_run),
    .ack     (wd_ack),
    .expired (expired)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_p0       <= IDLE;
      credit_p0      <= '0;
      disp_req_p0    <= 1'b0;
      coin_req_p0    <= 1'b0;
      coin_reject_p0 <= 1'b0;
      busy_p0        <= 1'b0;
      fault_p0       <= 1'b0;
      disp_req_p1    <= 1'b0;
      coin_req_p1    <= 1'b0;
    end else begin
      disp_req_p1    <= disp_req_p0;
      coin_req_p1    <= coin_req_p0;
      coin_reject_p0 <= coin_in;
      case (state_p0)
        IDLE: begin
          coin_reject_p0 <= coin_in & ~intake_ok;
          credit_p0      <= credit_post;
          // Both decisions see the credit including this cycle's coins.
          if (cancel) begin
            if (credit_post != '0) begin
              state_p0 <= CHANGE;
              busy_p0  <= 1'b1;
            end
          end else if (vend_sel && (credit_post >= CREDIT_W'(PRICE_Q))) begin
            credit_p0   <= credit_post - CREDIT_W'(PRICE_Q);
            disp_req_p0 <= 1'b1;
            state_p0    <= DISPENSE;
            busy_p0     <= 1'b1;
          end
        end
        DISPENSE: begin
          if (disp_req_p0 && disp_ack) begin
            disp_req_p0 <= 1'b0;
            if (credit_p0 != '0) begin
              state_p0 <= CHANGE;
            end else begin
              state_p0 <= IDLE;
              busy_p0  <= 1'b0;
            end
          end else if (expired) begin
            disp_req_p0 <= 1'b0;
            fault_p0    <= 1'b1;
            state_p0    <= FAULT;
          end
        end
        CHANGE: begin
          // coin_req is return-to-zero: every coin starts from a low cycle.
          if (!coin_req_p0) begin
            coin_req_p0 <= 1'b1;
          end else if (coin_ack) begin
            coin_req_p0 <= 1'b0;
            credit_p0   <= credit_p0 - CREDIT_W'(1);
            if (credit_p0 == CREDIT_W'(1)) begin
              state_p0 <= IDLE;
              busy_p0  <= 1'b0;
            end
          end else if (expired) begin
            coin_req_p0 <= 1'b0;
            fault_p0    <= 1'b1;
            state_p0    <= FAULT;
          end
        end
        FAULT: begin
          state_p0 <= FAULT;
        end
        default: begin
          state_p0 <= IDLE;
        end
      endcase
    end
  end

  assign disp_req    = disp_req_p0;
  assign coin_req    = coin_req_p0;
  assign coin_reject = coin_reject_p0;
  assign credit      = credit_p0;
  assign busy        = busy_p0;
  assign fault       = fault_p0;

endmodule

// File: tb/tb_vend_controller.sv
// Bench for vend_controller: directed vector table, hand-written corner
// sequences, then randomized traffic compared with a behavioural model.
module tb_vend_controller;

  localparam int PRICE = 4;
  localparam int MAXC  = 15;
  localparam int TMO   = 8;

  logic       clk;
  logic       reset;
  logic       quarter;
  logic       dollar;
  logic       vend_sel;
  logic       cancel;
  logic       disp_ack;
  logic       coin_ack;
  logic       disp_req;
  logic       coin_req;
  logic       coin_reject;
  logic [3:0] credit;
  logic       busy;
  logic       fault;

  vend_controller #(
    .PRICE_Q      (PRICE),
    .MAX_CREDIT_Q (MAXC),
    .CREDIT_W     (4),
    .TIMEOUT      (TMO)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .quarter     (quarter),
    .dollar      (dollar),
    .vend_sel    (vend_sel),
    .cancel      (cancel),
    .disp_ack    (disp_ack),
    .coin_ack    (coin_ack),
    .disp_req    (disp_req),
    .coin_req    (coin_req),
    .coin_reject (coin_reject),
    .credit      (credit),
    .busy        (busy),
    .fault       (fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, want %0d", name, act, exp);
  endtask

  task automatic chk_all(input string tag, input int dr, input int cr, input int rej,
                         input int cred, input int bsy, input int flt);
    chk({tag, ".disp_req"},    int'(disp_req),    dr);
    chk({tag, ".coin_req"},    int'(coin_req),    cr);
    chk({tag, ".coin_reject"}, int'(coin_reject), rej);
    chk({tag, ".credit"},      int'(credit),      cred);
    chk({tag, ".busy"},        int'(busy),        bsy);
    chk({tag, ".fault"},       int'(fault),       flt);
  endtask

  // ---------------- behavioural model ----------------
  typedef enum int {M_IDLE, M_VEND, M_REFUND, M_BROKEN} mmode_t;
  mmode_t m_mode;
  int     m_credit, m_cyc, m_rise;
  bit     m_dreq, m_creq, m_rej, m_fault;

  function automatic void model_step();
    int add;
    bit coins, req_was, ack_hit, late, dn, cn;
    if (reset) begin
      m_mode = M_IDLE; m_credit = 0; m_dreq = 0; m_creq = 0;
      m_rej = 0; m_fault = 0; m_cyc++;
      return;
    end
    coins   = quarter || dollar;
    add     = (quarter ? 1 : 0) + (dollar ? 4 : 0);
    req_was = m_dreq || m_creq;
    ack_hit = (m_dreq && disp_ack) || (m_creq && coin_ack);
    late    = req_was && !ack_hit && (m_cyc - m_rise + 1 >= TMO);
    dn = m_dreq; cn = m_creq;
    m_rej = coins && (m_mode != M_IDLE);
    case (m_mode)
      M_IDLE: begin
        if (coins) begin
          if (m_credit + add <= MAXC) m_credit += add;
          else m_rej = 1;
        end
        if (cancel) begin
          if (m_credit > 0) m_mode = M_REFUND;
        end else if (vend_sel && m_credit >= PRICE) begin
          m_credit -= PRICE; m_mode = M_VEND; dn = 1;
        end
      end
      M_VEND: begin
        if (disp_ack) begin
          dn = 0; m_mode = (m_credit > 0) ? M_REFUND : M_IDLE;
        end else if (late) begin
          dn = 0; m_mode = M_BROKEN; m_fault = 1;
        end
      end
      M_REFUND: begin
        if (!m_creq) cn = 1;
        else if (coin_ack) begin
          cn = 0; m_credit--;
          if (m_credit == 0) m_mode = M_IDLE;
        end else if (late) begin
          cn = 0; m_mode = M_BROKEN; m_fault = 1;
        end
      end
      default: ;
    endcase
    if ((dn && !m_dreq) || (cn && !m_creq)) m_rise = m_cyc + 1;
    m_dreq = dn; m_creq = cn;
    m_cyc++;
  endfunction

  // ---------------- stimulus helpers ----------------
  task automatic drive(input logic r, q, d, v, c, da, ca);
    reset = r; quarter = q; dollar = d; vend_sel = v;
    cancel = c; disp_ack = da; coin_ack = ca;
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic step(input logic r, q, d, v, c, da, ca);
    drive(r, q, d, v, c, da, ca);
    tick();
  endtask

  typedef struct {
    logic r, q, d, v, c, da, ca;
    int   dr, cr, rej, cred, bsy, flt;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input logic r, q, d, v, c, da, ca,
                              input int dr, cr, rej, cred, bsy, flt);
    vec_t x;
    x.r = r; x.q = q; x.d = d; x.v = v; x.c = c; x.da = da; x.ca = ca;
    x.dr = dr; x.cr = cr; x.rej = rej; x.cred = cred; x.bsy = bsy; x.flt = flt;
    return x;
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    m_mode = M_IDLE; m_credit = 0; m_cyc = 0; m_rise = 0;
    m_dreq = 0; m_creq = 0; m_rej = 0; m_fault = 0;
    drive(1, 0, 0, 0, 0, 0, 0);

    //               r q d v c da ca   dr cr rj cr bs ft
    // four quarters, vend, ack after 3 req cycles
    tbl.push_back(mk(0,1,0,0,0,0,0,   0,0,0, 1,0,0));
    tbl.push_back(mk(0,1,0,0,0,0,0,   0,0,0, 2,0,0));
    tbl.push_back(mk(0,1,0,0,0,0,0,   0,0,0, 3,0,0));
    tbl.push_back(mk(0,1,0,0,0,0,0,   0,0,0, 4,0,0));
    tbl.push_back(mk(0,0,0,1,0,0,0,   1,0,0, 0,1,0));
    tbl.push_back(mk(0,0,0,0,0,0,0,   1,0,0, 0,1,0));
    tbl.push_back(mk(0,0,0,0,0,0,0,   1,0,0, 0,1,0));
    tbl.push_back(mk(0,0,0,0,0,1,0,   0,0,0, 0,0,0));
    // quarter+dollar = 5, vend, one change coin
    tbl.push_back(mk(0,1,1,0,0,0,0,   0,0,0, 5,0,0));
    tbl.push_back(mk(0,0,0,1,0,0,0,   1,0,0, 1,1,0));
    tbl.push_back(mk(0,0,0,0,0,1,0,   0,0,0, 1,1,0));
    tbl.push_back(mk(0,0,0,0,0,0,0,   0,1,0, 1,1,0));
    tbl.push_back(mk(0,0,0,0,0,0,1,   0,0,0, 0,0,0));
    // credit 3: vend ignored, cancel returns three coins
    tbl.push_back(mk(0,1,0,0,0,0,0,   0,0,0, 1,0,0));
    tbl.push_back(mk(0,1,0,0,0,0,0,   0,0,0, 2,0,0));
    tbl.push_back(mk(0,1,0,0,0,0,0,   0,0,0, 3,0,0));
    tbl.push_back(mk(0,0,0,1,0,0,0,   0,0,0, 3,0,0));
    tbl.push_back(mk(0,0,0,0,1,0,0,   0,0,0, 3,1,0));
    tbl.push_back(mk(0,0,0,0,0,0,0,   0,1,0, 3,1,0));
    tbl.push_back(mk(0,0,0,0,0,0,1,   0,0,0, 2,1,0));
    tbl.push_back(mk(0,0,0,0,0,0,0,   0,1,0, 2,1,0));
    tbl.push_back(mk(0,0,0,0,0,0,1,   0,0,0, 1,1,0));
    tbl.push_back(mk(0,0,0,0,0,0,0,   0,1,0, 1,1,0));
    tbl.push_back(mk(0,0,0,0,0,0,1,   0,0,0, 0,0,0));
    tbl.push_back(mk(0,0,0,0,0,0,1,   0,0,0, 0,0,0));
    // overflow rejects at 12 and 15
    tbl.push_back(mk(0,0,1,0,0,0,0,   0,0,0, 4,0,0));
    tbl.push_back(mk(0,0,1,0,0,0,0,   0,0,0, 8,0,0));
    tbl.push_back(mk(0,0,1,0,0,0,0,   0,0,0,12,0,0));
    tbl.push_back(mk(0,0,1,0,0,0,0,   0,0,1,12,0,0));
    tbl.push_back(mk(0,0,0,0,0,0,0,   0,0,0,12,0,0));
    tbl.push_back(mk(0,1,1,0,0,0,0,   0,0,1,12,0,0));
    tbl.push_back(mk(0,1,0,0,0,0,0,   0,0,0,13,0,0));
    tbl.push_back(mk(0,1,0,0,0,0,0,   0,0,0,14,0,0));
    tbl.push_back(mk(0,1,0,0,0,0,0,   0,0,0,15,0,0));
    tbl.push_back(mk(0,1,0,0,0,0,0,   0,0,1,15,0,0));
    tbl.push_back(mk(1,0,0,0,0,0,0,   0,0,0, 0,0,0));
    // coin during DISPENSE, ack while coin_req low ignored
    tbl.push_back(mk(0,1,1,0,0,0,0,   0,0,0, 5,0,0));
    tbl.push_back(mk(0,0,0,1,0,0,0,   1,0,0, 1,1,0));
    tbl.push_back(mk(0,1,0,0,0,0,0,   1,0,1, 1,1,0));
    tbl.push_back(mk(0,0,0,0,0,1,0,   0,0,0, 1,1,0));
    tbl.push_back(mk(0,0,0,0,0,0,1,   0,1,0, 1,1,0));
    tbl.push_back(mk(0,0,0,0,0,0,1,   0,0,0, 0,0,0));
    // cancel beats vend_sel; coin during CHANGE rejected
    tbl.push_back(mk(0,0,1,0,0,0,0,   0,0,0, 4,0,0));
    tbl.push_back(mk(0,0,0,1,1,0,0,   0,0,0, 4,1,0));
    tbl.push_back(mk(0,1,0,0,0,0,0,   0,1,1, 4,1,0));
    tbl.push_back(mk(1,0,0,0,0,0,0,   0,0,0, 0,0,0));

    tick(); tick();
    chk_all("reset", 0, 0, 0, 0, 0, 0);

    for (int i = 0; i < tbl.size(); i++) begin
      step(tbl[i].r, tbl[i].q, tbl[i].d, tbl[i].v, tbl[i].c, tbl[i].da, tbl[i].ca);
      chk_all($sformatf("vec%0d", i), tbl[i].dr, tbl[i].cr, tbl[i].rej,
              tbl[i].cred, tbl[i].bsy, tbl[i].flt);
    end

    // watchdog expiry on the dispense handshake
    step(1,0,0,0,0,0,0);
    step(0,0,1,0,0,0,0);
    step(0,0,0,1,0,0,0);
    chk("tmo.req_cycle1", int'(disp_req), 1);
    for (int i = 2; i <= TMO; i++) begin
      step(0,0,0,0,0,0,0);
      chk($sformatf("tmo.req_cycle%0d", i), int'(disp_req), 1);
      chk($sformatf("tmo.nofault%0d", i), int'(fault), 0);
    end
    step(0,0,0,0,0,0,0);
    chk_all("tmo.fault", 0, 0, 0, 0, 1, 1);
    step(0,0,1,0,0,0,0);
    chk_all("tmo.coin_in_fault", 0, 0, 1, 0, 1, 1);
    step(0,0,0,1,1,1,1);
    chk_all("tmo.ignored", 0, 0, 0, 0, 1, 1);
    step(1,0,0,0,0,0,0);
    chk_all("tmo.reset", 0, 0, 0, 0, 0, 0);

    // ack on the TIMEOUT-th req cycle wins
    step(0,0,1,0,0,0,0);
    step(0,0,0,1,0,0,0);
    for (int i = 2; i <= TMO; i++) step(0,0,0,0,0,0,0);
    step(0,0,0,0,0,1,0);
    chk_all("tmo.ack_wins", 0, 0, 0, 0, 0, 0);

    // reset in the middle of change return
    step(0,1,0,0,0,0,0);
    step(0,1,0,0,0,0,0);
    step(0,0,0,0,1,0,0);
    chk_all("mid.change", 0, 0, 0, 2, 1, 0);
    step(0,0,0,0,0,0,0);
    chk_all("mid.req", 0, 1, 0, 2, 1, 0);
    step(1,0,0,0,0,0,0);
    chk_all("mid.reset", 0, 0, 0, 0, 0, 0);
    step(0,0,0,0,0,0,1);
    chk_all("mid.late_ack", 0, 0, 0, 0, 0, 0);
    step(0,1,0,0,0,0,0);
    chk_all("mid.idle_again", 0, 0, 0, 1, 0, 0);

    // randomized traffic against the model
    step(1,0,0,0,0,0,0);
    for (int i = 0; i < 3000; i++) begin
      drive($urandom_range(0, 99) < 2,
            $urandom_range(0, 4) == 0,
            $urandom_range(0, 9) == 0,
            $urandom_range(0, 5) == 0,
            $urandom_range(0, 14) == 0,
            $urandom_range(0, 2) == 0,
            $urandom_range(0, 2) == 0);
      tick();
      chk_all($sformatf("rnd%0d", i), int'(m_dreq), int'(m_creq), int'(m_rej),
              m_credit, int'(m_mode != M_IDLE), int'(m_fault));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
